// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: show-ahead valid/ready
// output with a sticky overflow flag and a saturating dropped-byte counter.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [7:0]        drop_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_pop  = !w_empty && dout_ready;
    assign w_push = rx_valid && (!w_full || w_pop);
    assign w_drop = rx_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the clearing cycle wins: the flag stays set, counter restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    assign dout       = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign dout_valid = !w_empty;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule
